// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter states, host command bytes and frame geometry.
package ps2_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StInhibit,
        StRequest,
        StSend,
        StAck,
        StWaitIdle,
        StDone
    } ps2_tx_state_t;

    localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
    localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;

    // start + 8 data + parity + stop
    localparam int unsigned PS2_FRAME_BITS = 11;

    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_host_transmitter_if.sv
// Command-byte handshake between a requester and the PS/2 host transmitter.
interface ps2_host_transmitter_if;

    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_error;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready,
        input  tx_busy,
        input  tx_done,
        input  tx_error
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready,
        output tx_busy,
        output tx_done,
        output tx_error
    );

endinterface

// File: rtl/ps2_falling_edge_detect.sv
// Falling-edge detector for a conditioned PS/2 line; shareable with the receive path.
module ps2_falling_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic ps2_line,
    output logic fall
);

    logic prev_clk;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_clk <= 1'b1;
        end else begin
            prev_clk <= ps2_line;
        end
    end

    assign fall = prev_clk & ~ps2_line;

endmodule

// File: rtl/ps2_host_transmitter.sv
// PS/2 host-to-device transmitter: request-to-send, 11-bit frame shift-out, ACK check,
// with a watchdog on device clock activity. Bus is driven through open-drain enables.
module ps2_host_transmitter
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned TIMEOUT_CYCLES = 750000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   keyboard_clk,
    input  logic                   keyboard_data,
    ps2_host_transmitter_if.slave  tx,
    output logic                   ps2_clk_oe,
    output logic                   ps2_data_oe
);

    localparam int unsigned InhW = $clog2(INHIBIT_CYCLES + 1);
    localparam int unsigned ToW  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [InhW-1:0] InhLast    = InhW'(INHIBIT_CYCLES - 1);
    localparam logic [ToW-1:0]  ToLimit    = ToW'(TIMEOUT_CYCLES);
    localparam logic [3:0]      BitRelease = 4'(PS2_FRAME_BITS - 2);

    ps2_tx_state_t   state_q, state_d;
    logic [InhW-1:0] inh_cnt_q, inh_cnt_d;
    logic [ToW-1:0]  to_cnt_q, to_cnt_d;
    logic [3:0]      bit_cnt_q, bit_cnt_d;
    logic [8:0]      shift_q, shift_d;
    logic            ack_ok_q, ack_ok_d;
    logic            clk_oe_q, clk_oe_d;
    logic            data_oe_q, data_oe_d;
    logic            ready_q, busy_q, done_q, error_q;
    logic            fall;

    ps2_falling_edge_detect u_fall (
        .clk      (clk),
        .rst_n    (rst_n),
        .ps2_line (keyboard_clk),
        .fall     (fall)
    );

    always_comb begin
        state_d   = state_q;
        inh_cnt_d = inh_cnt_q;
        to_cnt_d  = to_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        ack_ok_d  = ack_ok_q;
        clk_oe_d  = 1'b0;
        data_oe_d = data_oe_q;

        unique case (state_q)
            StIdle: begin
                data_oe_d = 1'b0;
                if (tx.tx_valid && ready_q) begin
                    state_d   = StInhibit;
                    clk_oe_d  = 1'b1;
                    inh_cnt_d = '0;
                    bit_cnt_d = '0;
                    shift_d   = {odd_parity(tx.tx_data), tx.tx_data};
                    ack_ok_d  = 1'b0;
                end
            end
            StInhibit: begin
                clk_oe_d = 1'b1;
                if (inh_cnt_q == InhLast) begin
                    state_d   = StRequest;
                    data_oe_d = 1'b1;
                end else begin
                    inh_cnt_d = inh_cnt_q + 1'b1;
                end
            end
            StRequest: begin
                // Releasing the clock with data held low presents the start bit.
                state_d   = StSend;
                data_oe_d = 1'b1;
                to_cnt_d  = '0;
            end
            StSend: begin
                if (fall) begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == BitRelease) begin
                        data_oe_d = 1'b0;
                        state_d   = StAck;
                    end else begin
                        data_oe_d = ~shift_q[0];
                        shift_d   = {1'b0, shift_q[8:1]};
                    end
                end
            end
            StAck: begin
                if (fall) begin
                    ack_ok_d  = ~keyboard_data;
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    state_d   = StWaitIdle;
                end
            end
            StWaitIdle: begin
                if (keyboard_clk && keyboard_data) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                data_oe_d = 1'b0;
                state_d   = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Watchdog on device clock activity; a fall restarts it.
        if (state_q inside {StSend, StAck, StWaitIdle}) begin
            to_cnt_d = fall ? '0 : to_cnt_q + 1'b1;
            if (to_cnt_d == ToLimit) begin
                state_d   = StDone;
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                ack_ok_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            inh_cnt_q <= '0;
            to_cnt_q  <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            ack_ok_q  <= 1'b0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            inh_cnt_q <= inh_cnt_d;
            to_cnt_q  <= to_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            ack_ok_q  <= ack_ok_d;
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
            ready_q   <= (state_d == StIdle);
            busy_q    <= (state_d != StIdle);
            done_q    <= (state_d == StDone);
            error_q   <= (state_d == StDone) & ~ack_ok_d;
        end
    end

    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;
    assign tx.tx_ready = ready_q;
    assign tx.tx_busy  = busy_q;
    assign tx.tx_done  = done_q;
    assign tx.tx_error = error_q;

endmodule
